// File: rtl/node_info_mgr.sv
// Per-node state holder for the EER-RL clustered WSN datapath: decodes packet metadata
// into hop/role/cluster-head/slot state and derives the initial Q-value with a serial divider.
module node_info_mgr #(
    parameter int                WORD_W    = 16,
    parameter int                FRAC_W    = 14,
    parameter logic [WORD_W-1:0] NODE_ID   = 16'h000C,
    parameter logic [WORD_W-1:0] HOPS_INIT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_MNI,
    input  logic [2:0]        fPktType,
    input  logic [WORD_W-1:0] energy,
    input  logic [WORD_W-1:0] e_min,
    input  logic [WORD_W-1:0] e_threshold,
    input  logic [WORD_W-1:0] destinationID,
    input  logic [WORD_W-1:0] sourceID,
    input  logic [WORD_W-1:0] hops,
    input  logic [WORD_W-1:0] timeslot,
    output logic [WORD_W-1:0] myNodeID,
    output logic [WORD_W-1:0] hopsFromSink,
    output logic [WORD_W-1:0] myQValue,
    output logic              role,
    output logic [WORD_W-1:0] myCH,
    output logic [WORD_W-1:0] myTimeslot,
    output logic              low_E,
    output logic              hb_lock,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_e;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_CHTS = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam int              CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    // The binary point only labels the energy/Q format; no logic depends on where it sits.
    if (FRAC_W > WORD_W) begin : g_frac_outside_word
    end

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hops_q, hops_d;
    logic [WORD_W-1:0] qval_q, qval_d;
    logic              role_q, role_d;
    logic [WORD_W-1:0] ch_q, ch_d;
    logic [WORD_W-1:0] ts_q, ts_d;
    logic              low_e_q, low_e_d;
    logic              hb_lock_q, hb_lock_d;
    logic [WORD_W-1:0] quo_q, quo_d;
    logic [WORD_W-1:0] rem_q, rem_d;
    logic [WORD_W-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [WORD_W:0]   rem_shift;
    logic [WORD_W-1:0] rem_diff;
    logic              q_bit;

    // quo_q starts as the numerator and shifts left, collecting quotient bits at the LSB.
    always_comb begin
        state_d   = state_q;
        hops_d    = hops_q;
        qval_d    = qval_q;
        role_d    = role_q;
        ch_d      = ch_q;
        ts_d      = ts_q;
        low_e_d   = low_e_q;
        hb_lock_d = hb_lock_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;

        rem_shift = {rem_q, quo_q[WORD_W-1]};
        q_bit     = (rem_shift >= {1'b0, divisor_q});
        rem_diff  = rem_shift[WORD_W-1:0] - divisor_q;

        case (state_q)
            IDLE: begin
                if (en_MNI) begin
                    case (fPktType)
                        PKT_HB: begin
                            if (!hb_lock_q || (hops < hops_q)) begin
                                hops_d    = hops;
                                hb_lock_d = 1'b1;
                                low_e_d   = (energy < e_threshold);
                                quo_d     = (energy > e_min) ? (energy - e_min) : '0;
                                divisor_d = (hops == '0) ? WORD_W'(1) : hops;
                                rem_d     = '0;
                                cnt_d     = '0;
                                state_d   = DIV;
                            end
                        end
                        PKT_CHE: begin
                            if (destinationID == NODE_ID) begin
                                role_d = 1'b1;
                                ch_d   = NODE_ID;
                                ts_d   = '0;
                            end
                        end
                        PKT_CHTS: begin
                            if (!role_q && (destinationID == NODE_ID)) begin
                                ch_d = sourceID;
                                ts_d = timeslot;
                            end
                        end
                        PKT_DATA: begin
                            hb_lock_d = 1'b0;
                            role_d    = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            DIV: begin
                rem_d = q_bit ? rem_diff : rem_shift[WORD_W-1:0];
                quo_d = {quo_q[WORD_W-2:0], q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    qval_d  = {quo_q[WORD_W-2:0], q_bit};
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hops_q    <= HOPS_INIT;
            qval_q    <= '0;
            role_q    <= 1'b0;
            ch_q      <= '0;
            ts_q      <= '0;
            low_e_q   <= 1'b0;
            hb_lock_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hops_q    <= hops_d;
            qval_q    <= qval_d;
            role_q    <= role_d;
            ch_q      <= ch_d;
            ts_q      <= ts_d;
            low_e_q   <= low_e_d;
            hb_lock_q <= hb_lock_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    assign myNodeID     = NODE_ID;
    assign hopsFromSink = hops_q;
    assign myQValue     = qval_q;
    assign role         = role_q;
    assign myCH         = ch_q;
    assign myTimeslot   = ts_q;
    assign low_E        = low_e_q;
    assign hb_lock      = hb_lock_q;
    assign busy         = (state_q == DIV);
    assign done         = (state_q == FIN);

endmodule

// File: doc/node_info_mgr.md
Name: node_info_mgr

Overview:
Parametrised next-generation per-node state holder for the EER-RL clustered WSN datapath. It decodes received packet metadata (heartbeat, cluster-head election, invitation, CH timeslot, data) and maintains the node's hop distance, role, cluster-head binding, TDMA slot and low-energy flag. It also computes the node's initial Q-value with an iterative divider. It sits between the packet parser (which pulses en_MNI) and the routing/Q-learning engine (which consumes the outputs).

Parameters:
WORD_W, 16, width of all data words (energy, IDs, hops, timeslot, Q-value)
FRAC_W, 14, fractional bits of energy/Q fixed-point (informational; the arithmetic is fraction-agnostic)
NODE_ID, 16'h000C, this node's constant ID
HOPS_INIT, all-ones (WORD_W bits), hopsFromSink value after reset (means "unknown")

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en_MNI  in  1  one-cycle strobe: packet fields are valid
fPktType  in  3  000 HB, 001 CHE, 010 INV, 100 CHTS, 101 DATA; other codes are ignored
energy  in  WORD_W  current residual energy
e_min  in  WORD_W  network minimum energy
e_threshold  in  WORD_W  low-energy threshold
destinationID  in  WORD_W  packet destination ID
sourceID  in  WORD_W  packet source ID (CH ID for CHTS)
hops  in  WORD_W  sender's hop count
timeslot  in  WORD_W  assigned TDMA slot
myNodeID  out  WORD_W  constant NODE_ID
hopsFromSink  out  WORD_W  accepted hop distance
myQValue  out  WORD_W  Q-value
role  out  1  0 member, 1 cluster head
myCH  out  WORD_W  bound cluster-head ID
myTimeslot  out  WORD_W  bound slot
low_E  out  1  energy below threshold
hb_lock  out  1  HB accepted this round
busy  out  1  divider running
done  out  1  one-cycle pulse when myQValue is updated

Behaviour:
- Reset (rst=1 at a clock edge), all values on the next edge: hopsFromSink=HOPS_INIT; myQValue=0; role=0; myCH=0; myTimeslot=0; low_E=0; hb_lock=0; busy=0; done=0; FSM=IDLE. A reset during DIV aborts the division with no done pulse.
- FSM states: IDLE, DIV, FIN. Packets are decoded only in IDLE. An en_MNI received in DIV or FIN is ignored entirely.
- HB, with en_MNI at edge N:
  - Accepted if hb_lock=0 or hops < hopsFromSink (strict).
  - On accept at N+1: hopsFromSink=hops; hb_lock=1; low_E=(energy<e_threshold), unsigned compare; numerator latched as max(energy-e_min,0); divisor latched as max(hops,1); FSM->DIV; busy=1.
  - On reject: no state change.
- DIV: unsigned restoring division, one quotient bit per cycle, exactly WORD_W cycles, busy=1 throughout.
  - Then FSM->FIN, busy=0, myQValue=quotient, done=1 for one cycle.
  - Next cycle FSM->IDLE.
  - Accepted HB at edge N gives done high during cycle N+WORD_W+1.
- CHE: if destinationID==NODE_ID, then role=1, myCH=NODE_ID, myTimeslot=0. Otherwise no change (role is not cleared).
- INV: no state change.
- CHTS:
  - Ignored if role=1.
  - If role=0 and destinationID==NODE_ID: myCH=sourceID, myTimeslot=timeslot.
- DATA: clears hb_lock and role (round ended). hopsFromSink, myQValue, myCH and myTimeslot are held.
- All decode updates other than HB take effect at N+1 with single-cycle latency. done is not pulsed for them.
- Widths: hops and timeslot are stored full WORD_W with no truncation. The subtraction saturates at 0, and the quotient never exceeds the numerator, so no overflow is possible.

Test Plan:
- Reset, then HB(hops=1, energy=0x8000, e_min=0x4000, e_thr=0x3333) -> hopsFromSink=1 at N+1, busy for 16 cycles, done with myQValue=0x4000, low_E=0, hb_lock=1.
- Second HB(hops=2, energy=0x7FC0) -> dropped: hopsFromSink=1, myQValue=0x4000, no busy. Then HB(hops=0, energy=0x2000) -> accepted: hopsFromSink=0, divisor=1, myQValue=0 (saturated), low_E=1.
- CHE dest=32 -> role=0. INV dest=32 -> no change. CHE dest=0x000C -> role=1, myCH=0x000C.
- With role=1: CHTS dest=0x000C, ts=5 -> myTimeslot unchanged. DATA -> role=0, hb_lock=0. Then CHTS src=21, dest=0x000C, ts=4 -> myCH=21, myTimeslot=4. CHTS dest=14 -> no change.
- HB(hops=4, energy=0x6000, e_min=0x4000) -> myQValue=0x0800. CHE dest=0x000C pulsed during busy -> ignored, role stays 0.
- rst asserted at cycle 5 of DIV -> all outputs at reset values next edge, no done pulse. A subsequent HB is accepted normally.
